// File: rtl/paralelo_serial_lanes_if.sv
// Handshake and serial-output bundle for the multi-lane parallel-to-serial converter.
interface paralelo_serial_lanes_if #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
);
    logic                   active;
    logic [LANES*WIDTH-1:0] data_in;
    logic                   valid_in;
    logic                   ready_out;
    logic [LANES-1:0]       serial_out;
    logic                   word_sync;
    logic                   data_flag;

    modport master (
        output active, data_in, valid_in,
        input  ready_out, serial_out, word_sync, data_flag
    );

    modport slave (
        input  active, data_in, valid_in,
        output ready_out, serial_out, word_sync, data_flag
    );
endinterface

// File: rtl/paralelo_serial_lanes.sv
// Multi-lane parallel-to-serial converter. All lanes share one word boundary;
// data/idle switching only happens there so the far-end aligner stays locked.

// One lane: a one-word holding buffer and an MSB-first shift register.
module paralelo_serial_lane #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             boundary,
    input  logic             sel_buf,
    input  logic             sel_in,
    input  logic             buf_we,
    input  logic [WIDTH-1:0] word_in,
    output logic             serial
);
    logic [WIDTH-1:0] buf_q;
    logic [WIDTH-1:0] sr;

    // Holding buffer captures the lane word on an accepted transfer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       buf_q <= '0;
        else if (buf_we) buf_q <= word_in;
    end

    // Load a new word at the boundary (buffer, bypassed input, or idle); shift otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr <= '0;
        end else if (boundary) begin
            if (sel_buf)     sr <= buf_q;
            else if (sel_in) sr <= word_in;
            else             sr <= IDLE_PATTERN;
        end else begin
            sr <= {sr[WIDTH-2:0], 1'b0};
        end
    end

    assign serial = sr[WIDTH-1];
endmodule

module paralelo_serial_lanes #(
    parameter int               WIDTH        = 8,
    parameter int               LANES        = 1,
    parameter logic [WIDTH-1:0] IDLE_PATTERN = 8'hBC
) (
    input logic                    clk,
    input logic                    reset,
    paralelo_serial_lanes_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {S_IDLE, S_DATA} state_t;

    state_t                       state, state_n;
    logic [CW-1:0]                bit_cnt;
    logic                         buf_v, buf_v_n;
    logic                         ready_r, sync_r;
    logic                         boundary, xfer, sel_buf, sel_in, buf_we;
    logic [LANES-1:0][WIDTH-1:0]  lane_word;
    logic [LANES-1:0]             ser;

    assign lane_word = bus.data_in;

    // Boundary decisions and buffer bookkeeping. A word arriving exactly at a
    // boundary with the buffer empty goes straight to the shift registers.
    always_comb begin
        boundary = (bit_cnt == CW'(WIDTH - 1));
        xfer     = bus.valid_in & ready_r;
        sel_buf  = boundary & bus.active & buf_v;
        sel_in   = boundary & bus.active & ~buf_v & xfer;
        buf_we   = xfer & ~sel_in;
        buf_v_n  = (buf_v & ~sel_buf) | buf_we;
        state_n  = state;
        if (boundary) state_n = (sel_buf | sel_in) ? S_DATA : S_IDLE;
    end

    // State, bit counter, buffer valid and registered handshake/sync outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            bit_cnt <= CW'(WIDTH - 1);
            buf_v   <= 1'b0;
            ready_r <= 1'b0;
            sync_r  <= 1'b0;
        end else begin
            state   <= state_n;
            bit_cnt <= boundary ? '0 : bit_cnt + CW'(1);
            buf_v   <= buf_v_n;
            ready_r <= ~buf_v_n;
            sync_r  <= boundary;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        paralelo_serial_lane #(
            .WIDTH        (WIDTH),
            .IDLE_PATTERN (IDLE_PATTERN)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .boundary (boundary),
            .sel_buf  (sel_buf),
            .sel_in   (sel_in),
            .buf_we   (buf_we),
            .word_in  (lane_word[k]),
            .serial   (ser[k])
        );
    end

    assign bus.serial_out = ser;
    assign bus.ready_out  = ready_r;
    assign bus.word_sync  = sync_r;
    assign bus.data_flag  = (state == S_DATA);
endmodule

// File: tb/tb_paralelo_serial_lanes.sv
// Bench for paralelo_serial_lanes: two configurations (8-bit x 2 lanes and
// 10-bit x 4 lanes), each with a queue-based reference model compared every cycle.
module tb_paralelo_serial_lanes;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad   = 0;
    bit   run_en = 1'b0;
    bit   done   = 1'b0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : m
        localparam int W  = (g == 1) ? 10 : 8;
        localparam int L  = (g == 1) ? 4 : 2;
        localparam int DW = W * L;
        localparam logic [W-1:0] IDLE = W'((g == 1) ? 10'h17C : 10'h0BC);

        paralelo_serial_lanes_if #(.WIDTH(W), .LANES(L)) bus ();

        paralelo_serial_lanes #(
            .WIDTH (W), .LANES (L), .IDLE_PATTERN (IDLE)
        ) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus.slave)
        );

        // Reference model: accepted words wait in a queue; each word slot is
        // either the oldest queued word (when active) or the idle pattern.
        logic [DW-1:0] qd[$];
        logic [DW-1:0] cur = '0;
        int pos = W - 1;
        bit started = 0, ready_m = 0, flag_m = 0, sync_m = 0, xfer_d = 0;

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                qd.delete();
                cur = '0; pos = W - 1;
                started = 0; ready_m = 0; flag_m = 0; sync_m = 0; xfer_d = 0;
            end else begin
                xfer_d = bus.valid_in && ready_m;
                if (xfer_d) qd.push_back(bus.data_in);
                if (pos == W - 1) begin
                    started = 1; pos = 0; sync_m = 1;
                    if (bus.active && qd.size() > 0) begin
                        cur = qd.pop_front(); flag_m = 1;
                    end else begin
                        cur = {L{IDLE}}; flag_m = 0;
                    end
                end else begin
                    pos++; sync_m = 0;
                end
                ready_m = (qd.size() == 0);
            end
        end

        always @(negedge clk) begin
            if (run_en && !reset) begin
                logic [L-1:0] es;
                for (int k = 0; k < L; k++) es[k] = started ? cur[k*W + (W-1-pos)] : 1'b0;
                chk($sformatf("cfg%0d_serial", g), 64'(bus.serial_out), 64'(es));
                chk($sformatf("cfg%0d_sync", g), 64'(bus.word_sync), 64'(sync_m));
                chk($sformatf("cfg%0d_flag", g), 64'(bus.data_flag), 64'(flag_m));
                chk($sformatf("cfg%0d_ready", g), 64'(bus.ready_out), 64'(ready_m));
            end
        end

        if (g == 1) begin : drv
            initial begin
                bus.active = 1'b1; bus.valid_in = 1'b0; bus.data_in = '0;
                @(negedge reset);
                #1;
                bus.data_in  = DW'({10'h2AA, 10'h155, 10'h000, 10'h3FF});
                bus.valid_in = 1'b1;
                while (!done) begin
                    step();
                    if (xfer_d || !bus.valid_in) begin
                        bus.valid_in = ($urandom_range(0, 2) != 0);
                        bus.data_in  = DW'({$urandom, $urandom});
                    end
                    if ($urandom_range(0, 29) == 0) bus.active = ~bus.active;
                end
            end
        end
    end

    // Word monitor for configuration 0: rebuilds each word per lane from word_sync.
    logic [7:0] lw0[$], lw1[$];
    bit         lf[$];
    logic [7:0] sh0 = '0, sh1 = '0;
    int         nb = -1;
    bit         fl = 0;
    int         lo_run = 0, lo_max = 0;

    always @(negedge clk) begin
        if (reset) begin
            nb = -1; lo_run = 0;
        end else if (run_en) begin
            if (m[0].bus.word_sync) begin nb = 0; fl = m[0].bus.data_flag; end
            if (nb >= 0) begin
                sh0 = {sh0[6:0], m[0].bus.serial_out[0]};
                sh1 = {sh1[6:0], m[0].bus.serial_out[1]};
                nb++;
                if (nb == 8) begin
                    lw0.push_back(sh0); lw1.push_back(sh1); lf.push_back(fl); nb = -1;
                end
            end
            if (!m[0].bus.ready_out) lo_run++; else lo_run = 0;
            if (lo_run > lo_max) lo_max = lo_run;
        end
    end

    task automatic clear_log();
        lw0.delete(); lw1.delete(); lf.delete();
    endtask

    task automatic send(input logic [15:0] d);
        bit got = 0;
        m[0].bus.data_in  = d;
        m[0].bus.valid_in = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = m[0].xfer_d;
        end
        chk("send_xfer", 64'(got), 64'd1);
    endtask

    initial begin
        logic [7:0] idle_a;
        int idx, i1, i2, cnt;
        bit ok, got;
        idle_a = 8'hBC;
        m[0].bus.active = 1'b0; m[0].bus.valid_in = 1'b0; m[0].bus.data_in = '0;
        #1 reset = 1'b1;
        #1;
        run_en = 1'b1;
        chk("rst_serial", 64'(m[0].bus.serial_out), 64'd0);
        chk("rst_sync", 64'(m[0].bus.word_sync), 64'd0);
        chk("rst_flag", 64'(m[0].bus.data_flag), 64'd0);
        chk("rst_ready", 64'(m[0].bus.ready_out), 64'd0);
        repeat (3) step();
        reset = 1'b0;
        chk("rel_ready_before_edge", 64'(m[0].bus.ready_out), 64'd0);

        // 1: idle words on both lanes, sync every 8 (and every 10 on the wide config)
        for (int i = 0; i < 32; i++) begin
            step();
            chk("t1_serial", 64'(m[0].bus.serial_out), 64'({2{idle_a[7 - (i % 8)]}}));
            chk("t1_sync", 64'(m[0].bus.word_sync), 64'(i % 8 == 0));
            chk("t1_flag", 64'(m[0].bus.data_flag), 64'd0);
            chk("t6_sync10", 64'(m[1].bus.word_sync), 64'(i % 10 == 0));
            if (i == 0) chk("t1_ready_after_1clk", 64'(m[0].bus.ready_out), 64'd1);
        end

        // 2: one data word A5/3C then idles resume
        clear_log();
        m[0].bus.active = 1'b1;
        send({8'h3C, 8'hA5});
        m[0].bus.valid_in = 1'b0;
        repeat (30) step();
        cnt = 0; idx = -1;
        foreach (lf[i]) if (lf[i]) begin cnt++; if (idx < 0) idx = i; end
        chk("t2_data_words", 64'(cnt), 64'd1);
        ok = (idx >= 0) && (idx + 1 < lf.size());
        chk("t2_found", 64'(ok), 64'd1);
        if (ok) begin
            chk("t2_lane0", 64'(lw0[idx]), 64'hA5);
            chk("t2_lane1", 64'(lw1[idx]), 64'h3C);
            chk("t2_idle_after", 64'({lf[idx+1], lw0[idx+1]}), 64'h0BC);
        end

        // 3: four back-to-back words, no idle gap
        clear_log();
        lo_max = 0;
        for (int w = 1; w <= 4; w++) send({8'(w), 8'(w)});
        m[0].bus.valid_in = 1'b0;
        repeat (40) step();
        idx = -1; cnt = 0;
        foreach (lf[i]) if (lf[i]) begin cnt++; if (idx < 0) idx = i; end
        ok = (cnt == 4) && (idx >= 0) && (idx + 3 < lf.size());
        if (ok) for (int j = 0; j < 4; j++)
            ok &= lf[idx+j] && (lw0[idx+j] == 8'(j + 1)) && (lw1[idx+j] == 8'(j + 1));
        chk("t3_stream", 64'(ok), 64'd1);
        chk("t3_ready_low_max_le7", 64'(lo_max <= 7), 64'd1);

        // 4: drop active at bit 3 of F0 with 0F buffered
        clear_log();
        send({8'hF0, 8'hF0});
        send({8'h0F, 8'h0F});
        m[0].bus.valid_in = 1'b0;
        step(); step();
        chk("t4_mid_data", 64'(m[0].bus.data_flag), 64'd1);
        m[0].bus.active = 1'b0;
        repeat (40) step();
        chk("t4_held_ready", 64'(m[0].bus.ready_out), 64'd0);
        chk("t4_idle_flag", 64'(m[0].bus.data_flag), 64'd0);
        m[0].bus.active = 1'b1;
        repeat (30) step();
        cnt = 0; i1 = -1; i2 = -1;
        foreach (lf[i]) if (lf[i]) begin
            cnt++;
            if (i1 < 0) i1 = i; else if (i2 < 0) i2 = i;
        end
        chk("t4_data_words", 64'(cnt), 64'd2);
        ok = (i1 >= 0) && (i2 > i1 + 1);
        chk("t4_gap", 64'(ok), 64'd1);
        if (ok) begin
            chk("t4_first", 64'({lw1[i1], lw0[i1]}), 64'hF0F0);
            chk("t4_second", 64'({lw1[i2], lw0[i2]}), 64'h0F0F);
        end

        // 5: reset in bit 4 of FF
        send({8'hFF, 8'hFF});
        m[0].bus.valid_in = 1'b0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = m[0].bus.word_sync && m[0].bus.data_flag;
        end
        chk("t5_ff_started", 64'(got), 64'd1);
        repeat (4) step();
        #2 reset = 1'b1;
        #1;
        chk("t5_serial", 64'(m[0].bus.serial_out), 64'd0);
        chk("t5_flag", 64'(m[0].bus.data_flag), 64'd0);
        chk("t5_ready", 64'(m[0].bus.ready_out), 64'd0);
        step();
        reset = 1'b0;
        clear_log();
        chk("t5_ready_rel", 64'(m[0].bus.ready_out), 64'd0);
        step();
        chk("t5_ready_1clk", 64'(m[0].bus.ready_out), 64'd1);
        repeat (30) step();
        ok = (lf.size() >= 3);
        foreach (lf[i]) ok &= !lf[i] && (lw0[i] == 8'hBC) && (lw1[i] == 8'hBC);
        chk("t5_idle_only", 64'(ok), 64'd1);

        // random traffic, checked every cycle by the model
        for (int i = 0; i < 800; i++) begin
            if (m[0].xfer_d || !m[0].bus.valid_in) begin
                m[0].bus.valid_in = ($urandom_range(0, 2) != 0);
                m[0].bus.data_in  = 16'($urandom);
            end
            if ($urandom_range(0, 24) == 0) m[0].bus.active = ~m[0].bus.active;
            step();
        end
        done = 1'b1;
        repeat (4) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
